// File: rtl/mem_pkg.sv
// Shared definitions for the store buffer: write-side FSM encoding,
// default RAM widths and the queued store entry layout.
package mem_pkg;

    localparam int SB_ADDR_W = 8;
    localparam int SB_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_WRITE = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Store queue storage: circular array with head/tail pointers, occupancy
// count and per-slot valid bits that let the forwarding logic scan all slots.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = sb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   push_entry,
    output entry_t                   head_entry,
    output entry_t                   next_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] head_ptr,
    output logic [DEPTH-1:0]         valid,
    output entry_t                   entries [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           mem_q [DEPTH];

    // Pointers are exactly PTR_W bits wide so they wrap modulo DEPTH for free.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= push_entry;
        end
    end

    assign head_entry = mem_q[head_q];
    assign next_entry = mem_q[head_q + PTR_W'(1)];
    assign count      = count_q;
    assign head_ptr   = head_q;
    assign valid      = valid_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entries
            assign entries[gi] = mem_q[gi];
        end
    endgenerate

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues datapath stores and retires them as registered write
// strobes when the fetch side leaves the RAM port free. STORE_FWD_EN enables
// store-to-load forwarding from the queue.
module store_buffer
    import mem_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_data,
    input  logic                   ram_busy,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    input  logic [ADDR_W-1:0]      fwd_addr,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    sb_state_e         state_q, state_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              push, pop;
    logic [CNT_W-1:0]  fifo_count, avail;
    logic [PTR_W-1:0]  head_ptr;
    logic [DEPTH-1:0]  valid;
    entry_t            req_entry, head_entry, next_entry, issue_entry;
    entry_t            entries [DEPTH];

    assign req_ready = (fifo_count < CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == ST_WRITE);
    assign req_entry = entry_t'{addr: req_addr, data: req_data};

    sb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .push_entry (req_entry),
        .head_entry (head_entry),
        .next_entry (next_entry),
        .count      (fifo_count),
        .head_ptr   (head_ptr),
        .valid      (valid),
        .entries    (entries)
    );

    // Leaving WRITE, the next store is the slot behind the head, or the
    // request being accepted on this same edge when the head was the last one.
    always_comb begin
        avail       = fifo_count;
        issue_entry = head_entry;
        if (pop) begin
            avail       = fifo_count - CNT_W'(1) + CNT_W'(push);
            issue_entry = (fifo_count == CNT_W'(1)) ? req_entry : next_entry;
        end

        state_d = ST_IDLE;
        if (avail != '0) begin
            state_d = ram_busy ? ST_ARB : ST_WRITE;
        end

        ram_we_d    = (state_d == ST_WRITE);
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (ram_we_d) begin
            ram_addr_d  = issue_entry.addr;
            ram_wdata_d = issue_entry.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign count     = fifo_count;
    assign empty     = (fifo_count == '0);

`ifdef STORE_FWD_EN
    logic [PTR_W-1:0] slot;

    // Scan oldest to youngest so the youngest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = head_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_ptr + PTR_W'(k);
            if (valid[slot] && (entries[slot].addr == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[slot].data;
            end
        end
    end
`else
    logic [DEPTH-1:0] unused_entry_bits;
    logic             unused_fwd;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unused
            assign unused_entry_bits[gi] = ^entries[gi];
        end
    endgenerate

    assign unused_fwd = ^{fwd_addr, head_ptr, valid, unused_entry_bits};
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_store_buffer;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          ram_busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [2:0]    count;
    logic          empty;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    int vectors = 0;
    int errors  = 0;
    logic [15:0] wr_log [$];

    store_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ram_busy  (ram_busy),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .count     (count),
        .empty     (empty),
        .fwd_addr  (fwd_addr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    // RAM side: a strobe seen mid-cycle is captured at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && ram_we === 1'b1) wr_log.push_back({ram_addr, ram_wdata});
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_addr = a; req_data = d;
        step;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 60 && (count !== 3'd0 || ram_we !== 1'b0); c++) step;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
        ram_busy = 1'b0; fwd_addr = '0;
        repeat (3) step;
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        vectors++; if (ram_addr !== 8'h00) begin errors++; $display("FAIL reset_ram_addr: got %h want 00", ram_addr); end
        vectors++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_wdata: got %h want 00", ram_wdata); end
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        vectors++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b want 0", fwd_hit); end
        vectors++; if (fwd_data !== 8'h00) begin errors++; $display("FAIL reset_fwd_data: got %h want 00", fwd_data); end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_single;
        int base = wr_log.size();
        ram_busy = 1'b0;
        req_valid = 1'b1; req_addr = 8'h12; req_data = 8'hAB;
        step;  // accepted at E0
        req_valid = 1'b0;
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_we_e0: got %b want 0", ram_we); end
        vectors++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_e0: got %0d want 1", count); end
        step;  // E1
        vectors++; if (ram_we !== 1'b1) begin errors++; $display("FAIL single_we_e1: got %b want 1", ram_we); end
        vectors++; if ({ram_addr, ram_wdata} !== 16'h12AB) begin errors++; $display("FAIL single_addr_data: got %h want 12ab", {ram_addr, ram_wdata}); end
        step;  // E2
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL single_we_e2: got %b want 0", ram_we); end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty); end
        vectors++; if (wr_log.size() != base + 1) begin errors++; $display("FAIL single_writes: got %0d want 1", wr_log.size() - base); end
    endtask

    task automatic test_back_to_back;
        int base = wr_log.size();
        logic [15:0] exp [5];
        logic [15:0] got;
        bit acc;
        ram_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_one(8'h50 + 8'(i), 8'hC0 + 8'(i));
            exp[i] = {8'h50 + 8'(i), 8'hC0 + 8'(i)};
        end
        exp[4] = 16'h54C4;
        vectors++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", req_ready); end
        req_valid = 1'b1; req_addr = 8'h54; req_data = 8'hC4;
        step; step;
        vectors++; if (count !== 3'd4) begin errors++; $display("FAIL held_count: got %0d want 4", count); end
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL held_we_busy: got %b want 0", ram_we); end
        ram_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            acc = req_valid && req_ready;
            step;
            if (acc) req_valid = 1'b0;
            vectors++;
            if (ram_we !== 1'b1 || {ram_addr, ram_wdata} !== exp[k]) begin
                errors++; $display("FAIL drain_cycle%0d: got we=%b %h want we=1 %h", k, ram_we, {ram_addr, ram_wdata}, exp[k]);
            end
        end
        for (int c = 0; c < 10 && req_valid; c++) begin
            acc = req_valid && req_ready;
            step;
            if (acc) req_valid = 1'b0;
        end
        wait_idle;
        vectors++; if (wr_log.size() != base + 5) begin errors++; $display("FAIL b2b_writes: got %0d want 5", wr_log.size() - base); end
        for (int i = 0; i < 5; i++) begin
            got = (base + i < wr_log.size()) ? wr_log[base + i] : 16'hxxxx;
            vectors++; if (got !== exp[i]) begin errors++; $display("FAIL b2b_order%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_busy_toggle;
        int base = wr_log.size();
        logic [15:0] got;
        bit bz;
        ram_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_one(8'h60 + 8'(i), 8'h30 + 8'(i));
        for (int c = 0; c < 40 && wr_log.size() < base + 4; c++) begin
            ram_busy = c[0];
            bz = ram_busy;
            step;
            vectors++; if (ram_we === 1'b1 && bz) begin errors++; $display("FAIL toggle_we_while_busy: got we=1 want 0 (cycle %0d)", c); end
        end
        ram_busy = 1'b0;
        wait_idle;
        vectors++; if (wr_log.size() != base + 4) begin errors++; $display("FAIL toggle_writes: got %0d want 4", wr_log.size() - base); end
        for (int i = 0; i < 4; i++) begin
            got = (base + i < wr_log.size()) ? wr_log[base + i] : 16'hxxxx;
            vectors++; if (got !== {8'h60 + 8'(i), 8'h30 + 8'(i)}) begin errors++; $display("FAIL toggle_order%0d: got %h want %h", i, got, {8'h60 + 8'(i), 8'h30 + 8'(i)}); end
        end
    endtask

    task automatic test_push_pop;
        int base = wr_log.size();
        logic [15:0] exp [3] = '{16'h7011, 16'h7122, 16'h7233};
        logic [15:0] got;
        ram_busy = 1'b1;
        push_one(8'h70, 8'h11);
        push_one(8'h71, 8'h22);
        ram_busy = 1'b0;
        step;
        vectors++; if (ram_we !== 1'b1) begin errors++; $display("FAIL pp_we: got %b want 1", ram_we); end
        req_valid = 1'b1; req_addr = 8'h72; req_data = 8'h33; ram_busy = 1'b1;
        step;
        req_valid = 1'b0;
        vectors++; if (count !== 3'd2) begin errors++; $display("FAIL pp_count: got %0d want 2", count); end
        ram_busy = 1'b0;
        wait_idle;
        for (int i = 0; i < 3; i++) begin
            got = (base + i < wr_log.size()) ? wr_log[base + i] : 16'hxxxx;
            vectors++; if (got !== exp[i]) begin errors++; $display("FAIL pp_order%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_reset_mid_write;
        int base = wr_log.size();
        ram_busy = 1'b1;
        for (int i = 0; i < 3; i++) push_one(8'h80 + 8'(i), 8'h90 + 8'(i));
        ram_busy = 1'b0;
        step;
        vectors++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b want 1", ram_we); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_async_we: got %b want 0", ram_we); end
        vectors++; if (count !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_async_empty: got %b want 1", empty); end
        step;
        rst_n = 1'b1;
        repeat (10) step;
        vectors++; if (wr_log.size() != base) begin errors++; $display("FAIL rst_no_writes: got %0d want 0", wr_log.size() - base); end
    endtask

    task automatic test_forwarding;
        int base = wr_log.size();
        ram_busy = 1'b1;
        push_one(8'h20, 8'h01);
        push_one(8'h20, 8'h02);
        push_one(8'h30, 8'h55);
        fwd_addr = 8'h20; #1;
        vectors++; if ({fwd_hit, fwd_data} !== (FWD ? 9'h102 : 9'h000)) begin errors++; $display("FAIL fwd_youngest: got %h want %h", {fwd_hit, fwd_data}, FWD ? 9'h102 : 9'h000); end
        fwd_addr = 8'h21; #1;
        vectors++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b want 0", fwd_hit); end
        fwd_addr = 8'h30; #1;
        vectors++; if ({fwd_hit, fwd_data} !== (FWD ? 9'h155 : 9'h000)) begin errors++; $display("FAIL fwd_other: got %h want %h", {fwd_hit, fwd_data}, FWD ? 9'h155 : 9'h000); end
        fwd_addr = 8'h20;
        ram_busy = 1'b0;
        step;  // head 0x20<-0x01 in WRITE
        vectors++; if ({fwd_hit, fwd_data} !== (FWD ? 9'h102 : 9'h000)) begin errors++; $display("FAIL fwd_during_write: got %h want %h", {fwd_hit, fwd_data}, FWD ? 9'h102 : 9'h000); end
        step;  // 0x20<-0x02 in WRITE
        vectors++; if ({fwd_hit, fwd_data} !== (FWD ? 9'h102 : 9'h000)) begin errors++; $display("FAIL fwd_head_only: got %h want %h", {fwd_hit, fwd_data}, FWD ? 9'h102 : 9'h000); end
        step;  // only 0x30 remains
        vectors++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_after_pop: got %b want 0", fwd_hit); end
        wait_idle;
        fwd_addr = 8'h30; #1;
        vectors++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_empty: got %b want 0", fwd_hit); end
        vectors++; if (wr_log.size() != base + 3) begin errors++; $display("FAIL fwd_writes: got %0d want 3", wr_log.size() - base); end
    endtask

    task automatic test_random;
        logic [15:0] mq [$];
        logic [15:0] acc_entry;
        logic        exp_hit;
        logic [7:0]  exp_data;
        bit          will_push, bz, traffic;
        req_valid = 1'b0; ram_busy = 1'b0;
        for (int c = 0; c < 400; c++) begin
            traffic = (c < 340);
            if (!req_valid && traffic && $urandom_range(0, 2) != 0) begin
                req_valid = 1'b1;
                req_addr  = 8'h40 + 8'($urandom_range(0, 7));
                req_data  = 8'($urandom);
            end
            ram_busy = traffic ? ($urandom_range(0, 3) == 0) : 1'b0;
            fwd_addr = 8'h40 + 8'($urandom_range(0, 7));
            #1;
            exp_hit = 1'b0; exp_data = 8'h00;
            for (int i = 0; i < mq.size(); i++) begin
                if (FWD && mq[i][15:8] == fwd_addr) begin exp_hit = 1'b1; exp_data = mq[i][7:0]; end
            end
            vectors++; if ({fwd_hit, fwd_data} !== {exp_hit, exp_data}) begin errors++; $display("FAIL rnd_fwd c%0d: got %h want %h", c, {fwd_hit, fwd_data}, {exp_hit, exp_data}); end
            will_push = req_valid && (mq.size() < DEPTH);
            if (ram_we === 1'b1) begin
                vectors++;
                if (mq.size() == 0) begin
                    errors++; $display("FAIL rnd_write c%0d: got %h want no write", c, {ram_addr, ram_wdata});
                end else begin
                    if ({ram_addr, ram_wdata} !== mq[0]) begin errors++; $display("FAIL rnd_write c%0d: got %h want %h", c, {ram_addr, ram_wdata}, mq[0]); end
                    void'(mq.pop_front());
                end
            end
            acc_entry = {req_addr, req_data};
            bz = ram_busy;
            step;
            if (will_push) begin mq.push_back(acc_entry); req_valid = 1'b0; end
            vectors++; if (count !== 3'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, mq.size()); end
            vectors++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty c%0d: got %b want %b", c, empty, mq.size() == 0); end
            vectors++; if (req_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, mq.size() < DEPTH); end
            vectors++; if (ram_we === 1'b1 && bz) begin errors++; $display("FAIL rnd_we_while_busy c%0d: got we=1 want 0", c); end
        end
        vectors++; if (mq.size() != 0 || count !== 3'd0) begin errors++; $display("FAIL rnd_drained: got %0d left want 0", mq.size()); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_busy_toggle;
        test_push_pop;
        test_reset_mid_write;
        test_forwarding;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
